cam_fifo_ctrl: RTL and testbench
================================

# cam_fifo_ctrl

Capture-and-drain sequencer sitting between the camera byte interface and the camera FIFO. It arms on a software start, aligns to the next frame start (VSYNC falling edge), writes every valid HREF byte into the FIFO, and drains the FIFO to a downstream valid/ready consumer. It owns the FIFO write, read and clear strobes, detects overflow, and reports per-frame byte count and completion.

## Interface
- DATA_WIDTH, 8: camera byte / FIFO word width.
- CNT_WIDTH, 16: width of the frame byte counter.
- FRAME_BYTES, 2*160*120: byte limit per frame; capture truncates at this count.

- clk  in  1  single system clock; all camera inputs are already synchronized to it.
- rst  in  1  reset rst, synchronous, active-high.
- start  in  1  one-cycle arm request; ignored unless state is IDLE.
- abort  in  1  one-cycle request to return to IDLE from any state.
- cam_vsync  in  1  frame sync; high = vertical blanking.
- cam_href  in  1  line valid.
- cam_de  in  1  byte strobe (one clk per pixel byte).
- cam_data  in  DATA_WIDTH  camera byte.
- fifo_rst  out  1  FIFO clear pulse.
- fifo_wr  out  1  FIFO write strobe.
- fifo_wdata  out  DATA_WIDTH  FIFO write data.
- fifo_rd  out  1  FIFO read strobe.
- fifo_rdata  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd.
- fifo_full, fifo_empty  in  1  FIFO status.
- out_data  out  DATA_WIDTH  drained byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle completion pulse.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- byte_cnt  out  CNT_WIDTH  bytes accepted in the current/last frame.

## Operation
- States: IDLE, CLEAR, WAIT_VS, CAPTURE, FLUSH.
- IDLE + start -> CLEAR. CLEAR lasts 1 cycle with fifo_rst=1 and clears byte_cnt and overflow; then go to WAIT_VS.
- WAIT_VS: go to CAPTURE on a VSYNC falling edge (registered vsync_q=1, cam_vsync=0). Capture never starts mid-frame.
- CAPTURE: each cycle with cam_href & cam_de high is a sample.
  - If fifo_full=0 and byte_cnt<FRAME_BYTES, accept the sample and increment byte_cnt.
  - If fifo_full=1, drop the sample and set overflow; byte_cnt does not increment.
  - If byte_cnt=FRAME_BYTES, ignore the sample silently.
- CAPTURE leaves to FLUSH on a VSYNC rising edge or when byte_cnt reaches FRAME_BYTES.
- FLUSH: wait until fifo_empty=1, no read is pending and out_valid=0. Then pulse frame_done and go to IDLE.
- Drain runs in CLEAR-excluded states WAIT_VS, CAPTURE and FLUSH:
  - fifo_rd = !fifo_empty & !rd_pend & (!out_valid | out_ready).
  - rd_pend is set the cycle after fifo_rd, and fifo_rdata is captured into out_data at the end of that cycle.
  - At most one read is outstanding.
- abort: go to IDLE next cycle, clear rd_pend and out_valid, and hold fifo_wr and fifo_rd at 0. byte_cnt and overflow keep their values. frame_done is not pulsed.
- byte_cnt saturates at FRAME_BYTES. It wraps nowhere.

## Timing
- Reset values: fifo_rst=0, fifo_wr=0, fifo_wdata=0, fifo_rd=0, out_data=0, out_valid=0, busy=0, frame_done=0, overflow=0, byte_cnt=0; state IDLE.
- rst mid-operation behaves like abort and also clears byte_cnt and overflow.
- Write latency: a sample accepted at edge N gives fifo_wr=1 and fifo_wdata=sample for exactly one cycle after edge N. fifo_wr and fifo_wdata are registered.
- Read: fifo_rd is combinational from registered state. Read-to-out_valid latency is 2 cycles. Peak drain rate is 1 byte per 2 cycles.
- out_data must stay stable while out_valid=1 & out_ready=0.
- A start pulse in any state other than IDLE is ignored. A start and an abort in the same cycle: abort wins.
- VSYNC falling and rising edges are each detected one cycle after the input transition.

## Configuration
- CAM_FIFO_CTRL_CONTINUOUS_EN:
  - Defined: FLUSH completion pulses frame_done and goes to CLEAR, then WAIT_VS. This gives continuous frame capture; only abort returns to IDLE.
  - Undefined: single-shot capture; FLUSH completion goes to IDLE.

## Test plan
- Reset then idle: hold rst 2 cycles with random camera activity -> all outputs stay 0 and fifo_wr is never asserted.
- Single frame: start, then VSYNC 1->0, then 10 bytes 0x01..0x0A with out_ready=1, then VSYNC 0->1 -> out stream is 0x01..0x0A in order, byte_cnt=10, one frame_done pulse, busy=0 afterwards.
- Mid-frame arm: start while VSYNC is low and HREF is active -> no fifo_wr until the next VSYNC falling edge.
- Overflow: fifo_full forced to 1 for 3 samples during CAPTURE -> those 3 samples give no fifo_wr, overflow=1, byte_cnt excludes them; overflow clears on the next start.
- Backpressure: out_ready=0 for 20 cycles with the FIFO non-empty -> out_data is stable, exactly one fifo_rd is issued, and no byte is lost once ready returns.
- Truncation and abort: FRAME_BYTES=4 with 6 bytes sent -> 4 written, byte_cnt=4, FLUSH. Abort during CAPTURE -> IDLE next cycle, no frame_done. With CAM_FIFO_CTRL_CONTINUOUS_EN, a second frame is captured without a second start.

Source files
------------

// File: rtl/cam_fifo_ctrl.sv
// cam_fifo_ctrl
// Capture-and-drain sequencer between the camera byte interface and the
// camera FIFO. Arms on a start pulse, aligns to the next VSYNC falling edge,
// writes every valid HREF/DE byte into the FIFO, and drains the FIFO to a
// valid/ready consumer. Owns the FIFO clear, write and read strobes, flags
// overflow and reports the per-frame byte count and completion.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   start, abort             arm request (IDLE only) / return to IDLE
//   cam_vsync, cam_href,
//   cam_de, cam_data         synchronized camera byte interface
//   fifo_rst, fifo_wr,
//   fifo_wdata, fifo_rd      FIFO clear / write / read controls
//   fifo_rdata               FIFO read data, valid the cycle after fifo_rd
//   fifo_full, fifo_empty    FIFO status
//   out_data, out_valid,
//   out_ready                drained byte stream (valid/ready)
//   busy, frame_done,
//   overflow, byte_cnt       status
//
// Configuration macro: CAM_FIFO_CTRL_CONTINUOUS_EN
//   defined   -> after a frame completes the block re-clears the FIFO and
//                waits for the next frame; only abort returns to IDLE.
//   undefined -> single-shot capture, returns to IDLE after each frame.

module cam_fifo_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int CNT_WIDTH   = 16,
  parameter int FRAME_BYTES = 2*160*120
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  cam_vsync,
  input  logic                  cam_href,
  input  logic                  cam_de,
  input  logic [DATA_WIDTH-1:0] cam_data,
  output logic                  fifo_rst,
  output logic                  fifo_wr,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  byte_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WAIT_VS,
    ST_CAPTURE,
    ST_FLUSH
  } state_t;

  localparam logic [CNT_WIDTH-1:0] FRAME_MAX = CNT_WIDTH'(FRAME_BYTES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_t                  state_q, state_d;
  logic                    vsync_q, vsync_d;
  logic                    fifo_rst_q, fifo_rst_d;
  logic                    fifo_wr_q, fifo_wr_d;
  logic [DATA_WIDTH-1:0]   fifo_wdata_q, fifo_wdata_d;
  logic                    rd_pend_q, rd_pend_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    frame_done_q, frame_done_d;
  logic                    overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]    byte_cnt_q, byte_cnt_d;

  logic vs_fall, vs_rise;
  logic draining, rd_now;
  logic sample, below_limit, accept, drop;
  logic flush_done;

  assign vs_fall     = vsync_q & ~cam_vsync;
  assign vs_rise     = ~vsync_q & cam_vsync;

  // The drain runs in every active state except CLEAR, where the FIFO is
  // being wiped. Only one read may be outstanding, and a read is only issued
  // when the output register is free or being consumed this cycle.
  assign draining    = (state_q == ST_WAIT_VS) || (state_q == ST_CAPTURE) ||
                       (state_q == ST_FLUSH);
  assign rd_now      = draining & ~fifo_empty & ~rd_pend_q &
                       (~out_valid_q | out_ready) & ~abort & ~rst;

  assign sample      = (state_q == ST_CAPTURE) & cam_href & cam_de;
  assign below_limit = (byte_cnt_q < FRAME_MAX);
  assign accept      = sample & ~fifo_full & below_limit;
  assign drop        = sample & fifo_full & below_limit;

  // A write issued on the last CAPTURE cycle is still in flight during the
  // first FLUSH cycle, so fifo_empty alone cannot be trusted until it lands.
  assign flush_done  = fifo_empty & ~rd_pend_q & ~out_valid_q & ~fifo_wr_q;

  // Next-state and next-output logic for the whole sequencer.
  always_comb begin
    state_d      = state_q;
    vsync_d      = cam_vsync;
    fifo_rst_d   = 1'b0;
    fifo_wr_d    = 1'b0;
    fifo_wdata_d = fifo_wdata_q;
    rd_pend_d    = rd_now;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    byte_cnt_d   = byte_cnt_q;

    // Read data arrives the cycle after the read strobe; load it at the end
    // of that cycle. Otherwise hold the byte until the consumer takes it.
    if (rd_pend_q) begin
      out_data_d  = fifo_rdata;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
        end
      end
      // byte_cnt and overflow are cleared at the end of CLEAR so that, in
      // continuous mode, the previous frame's count is still visible while
      // frame_done is high.
      ST_CLEAR: begin
        byte_cnt_d = '0;
        overflow_d = 1'b0;
        state_d    = ST_WAIT_VS;
      end
      ST_WAIT_VS: begin
        if (vs_fall) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (accept) begin
          fifo_wr_d    = 1'b1;
          fifo_wdata_d = cam_data;
          byte_cnt_d   = byte_cnt_q + CNT_ONE;
        end
        if (drop) begin
          overflow_d = 1'b1;
        end
        if (vs_rise || (byte_cnt_d == FRAME_MAX)) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_done) begin
          frame_done_d = 1'b1;
`ifdef CAM_FIFO_CTRL_CONTINUOUS_EN
          state_d      = ST_CLEAR;
`else
          state_d      = ST_IDLE;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    fifo_rst_d = (state_d == ST_CLEAR);

    // Abort overrides everything, including a simultaneous start. The
    // frame statistics are kept so software can inspect the partial frame.
    if (abort) begin
      state_d      = ST_IDLE;
      rd_pend_d    = 1'b0;
      out_valid_d  = 1'b0;
      fifo_wr_d    = 1'b0;
      fifo_wdata_d = fifo_wdata_q;
      fifo_rst_d   = 1'b0;
      frame_done_d = 1'b0;
      byte_cnt_d   = byte_cnt_q;
      overflow_d   = overflow_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vsync_q      <= 1'b0;
      fifo_rst_q   <= 1'b0;
      fifo_wr_q    <= 1'b0;
      fifo_wdata_q <= '0;
      rd_pend_q    <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      byte_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      fifo_rst_q   <= fifo_rst_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_wdata_q <= fifo_wdata_d;
      rd_pend_q    <= rd_pend_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      byte_cnt_q   <= byte_cnt_d;
    end
  end

  assign fifo_rst   = fifo_rst_q;
  assign fifo_wr    = fifo_wr_q;
  assign fifo_wdata = fifo_wdata_q;
  assign fifo_rd    = rd_now;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_cam_fifo_ctrl.sv
// tb_cam_fifo_ctrl
// Directed sequence with randomized data, gaps and consumer backpressure
// around cam_fifo_ctrl. A queue-based FIFO model sits on the FIFO side; a
// frame-level reference model predicts the byte stream, count and overflow.

module tb_cam_fifo_ctrl;

  localparam int DW    = 8;
  localparam int CW    = 16;
  localparam int FB    = 12;
  localparam int DEPTH = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic          cam_vsync;
  logic          cam_href;
  logic          cam_de;
  logic [DW-1:0] cam_data;
  logic          fifo_rst;
  logic          fifo_wr;
  logic [DW-1:0] fifo_wdata;
  logic          fifo_rd;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          frame_done;
  logic          overflow;
  logic [CW-1:0] byte_cnt;

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;
  logic force_full = 1'b0;

  logic [DW-1:0] fq[$];
  int fcount = 0;

  int wr_count = 0;
  int rd_count = 0;
  int fd_count = 0;
  int last_done_cnt = -1;
  logic last_done_ovf = 1'b0;
  logic [DW-1:0] out_log[$];

  logic [DW-1:0] exp_q[$];
  int exp_cnt = 0;
  logic exp_ovf = 1'b0;

  cam_fifo_ctrl #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW),
    .FRAME_BYTES(FB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_de    (cam_de),
    .cam_data  (cam_data),
    .fifo_rst  (fifo_rst),
    .fifo_wr   (fifo_wr),
    .fifo_wdata(fifo_wdata),
    .fifo_rd   (fifo_rd),
    .fifo_rdata(fifo_rdata),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .frame_done(frame_done),
    .overflow  (overflow),
    .byte_cnt  (byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty = (fcount == 0);
  assign fifo_full  = force_full | (fcount >= DEPTH);

  // Synchronous FIFO model: clear, read (data next cycle), write.
  always @(posedge clk) begin
    if (rst || fifo_rst) begin
      fq.delete();
    end else begin
      if (fifo_rd && fq.size() > 0) fifo_rdata <= fq.pop_front();
      if (fifo_wr) fq.push_back(fifo_wdata);
    end
    fcount <= fq.size();
  end

  // Event monitor.
  always @(posedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) out_log.push_back(out_data);
      if (fifo_wr) wr_count++;
      if (fifo_rd) rd_count++;
      if (frame_done) begin
        fd_count++;
        last_done_cnt = int'(byte_cnt);
        last_done_ovf = overflow;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    exp_q.delete();
    exp_cnt = 0;
    exp_ovf = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulseAbort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // One frame: blanking, VSYNC fall, nbytes samples with random gaps, VSYNC
  // rise. Samples with index in [full_lo, full_hi] see a full FIFO.
  task automatic applyStimulus(input int nbytes, input bit seq_data, input int full_lo, input int full_hi);
    cam_vsync = 1'b1; cam_href = 1'b0; cam_de = 1'b0;
    repeat (3) tick();
    cam_vsync = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < nbytes; i++) begin
      int gap;
      logic [DW-1:0] b;
      bit full;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        cam_href = 1'($urandom_range(0, 1));
        cam_de   = 1'b0;
        cam_data = DW'($urandom);
        tick();
      end
      b    = seq_data ? DW'(i + 1) : DW'($urandom);
      full = (i >= full_lo) && (i <= full_hi);
      cam_href = 1'b1; cam_de = 1'b1; cam_data = b; force_full = full;
      if (exp_cnt < FB) begin
        if (full) exp_ovf = 1'b1;
        else begin
          exp_q.push_back(b);
          exp_cnt++;
        end
      end
      tick();
      cam_de = 1'b0; force_full = 1'b0;
    end
    cam_href = 1'b0;
    repeat (2) tick();
    cam_vsync = 1'b1;
    tick();
  endtask

  task automatic checkFrame(input string tag, input int fd0, input int ob, input int wb);
    int mism;
    int n;
    for (int k = 0; k < 400 && fd_count == fd0; k++) tick();
    checkOutput({tag, "_done_seen"}, (fd_count > fd0), 1);
    repeat (5) tick();
    checkOutput({tag, "_done_pulses"}, fd_count - fd0, 1);
    checkOutput({tag, "_byte_cnt"}, last_done_cnt, exp_cnt);
    checkOutput({tag, "_overflow"}, last_done_ovf, exp_ovf);
    checkOutput({tag, "_stream_len"}, out_log.size() - ob, exp_q.size());
    checkOutput({tag, "_wr_count"}, wr_count - wb, exp_q.size());
    mism = 0;
    n = out_log.size() - ob;
    if (n > exp_q.size()) n = exp_q.size();
    for (int i = 0; i < n; i++) if (out_log[ob + i] !== exp_q[i]) mism++;
    checkOutput({tag, "_stream_data"}, mism, 0);
`ifdef CAM_FIFO_CTRL_CONTINUOUS_EN
    checkOutput({tag, "_busy_after"}, busy, 1);
    pulseAbort();
`else
    checkOutput({tag, "_busy_after"}, busy, 0);
`endif
  endtask

  initial begin
    int fd0, ob, wb, rb;
    logic [DW-1:0] d0;
    int changes;

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cam_vsync = 1'b1; cam_href = 1'b0; cam_de = 1'b0; cam_data = '0;
    out_ready = 1'b1; fifo_rdata = '0;

    // Reset with random camera activity.
    for (int i = 0; i < 2; i++) begin
      cam_vsync = 1'($urandom); cam_href = 1'($urandom); cam_de = 1'($urandom);
      cam_data = DW'($urandom);
      tick();
      checkOutput("reset_flags", {fifo_rst, fifo_wr, fifo_rd, out_valid, busy, frame_done, overflow}, 0);
      checkOutput("reset_data", {fifo_wdata, out_data, byte_cnt}, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cam_vsync = 1'($urandom); cam_href = 1'($urandom); cam_de = 1'($urandom);
      cam_data = DW'($urandom);
      tick();
    end
    checkOutput("idle_no_wr", wr_count, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_byte_cnt", byte_cnt, 0);

    // Single frame, sequential bytes, consumer always ready.
    $display("[TB] single frame");
    cam_vsync = 1'b1; cam_href = 1'b0; cam_de = 1'b0;
    rdy_mode = 0;
    resetModel();
    fd0 = fd_count; ob = out_log.size(); wb = wr_count;
    pulseStart();
    checkOutput("clear_fifo_rst", fifo_rst, 1);
    checkOutput("clear_busy", busy, 1);
    tick();
    checkOutput("clear_pulse_width", fifo_rst, 0);
    applyStimulus(10, 1'b1, -1, -1);
    checkFrame("single", fd0, ob, wb);

    // Arm mid-frame: nothing may be written before the next VSYNC fall.
    $display("[TB] mid-frame arm");
    rdy_mode = 1;
    resetModel();
    cam_vsync = 1'b0; cam_href = 1'b1;
    tick();
    fd0 = fd_count; ob = out_log.size(); wb = wr_count;
    pulseStart();
    for (int i = 0; i < 10; i++) begin
      cam_de = 1'($urandom); cam_data = DW'($urandom);
      tick();
    end
    checkOutput("midframe_no_wr", wr_count - wb, 0);
    checkOutput("midframe_busy", busy, 1);
    cam_de = 1'b0;
    applyStimulus(6, 1'b0, -1, -1);
    checkFrame("midframe", fd0, ob, wb);

    // Overflow: three samples dropped while the FIFO reports full.
    $display("[TB] overflow");
    resetModel();
    fd0 = fd_count; ob = out_log.size(); wb = wr_count;
    pulseStart();
    applyStimulus(8, 1'b0, 2, 4);
    checkFrame("ovf", fd0, ob, wb);

    // Restart clears overflow/byte_cnt; then backpressure.
    $display("[TB] backpressure");
    resetModel();
    rdy_mode = 2;
    fd0 = fd_count; ob = out_log.size(); wb = wr_count; rb = rd_count;
    pulseStart();
    tick();
    checkOutput("restart_ovf_clear", overflow, 0);
    checkOutput("restart_cnt_clear", byte_cnt, 0);
    applyStimulus(6, 1'b0, -1, -1);
    checkOutput("bp_valid_held", out_valid, 1);
    d0 = out_data;
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_data !== d0 || out_valid !== 1'b1) changes++;
    end
    checkOutput("bp_data_stable", changes, 0);
    checkOutput("bp_single_read", rd_count - rb, 1);
    rdy_mode = 1;
    checkFrame("bp", fd0, ob, wb);

    // Truncation at FRAME_BYTES.
    $display("[TB] truncation");
    resetModel();
    fd0 = fd_count; ob = out_log.size(); wb = wr_count;
    pulseStart();
    applyStimulus(FB + 3, 1'b0, -1, -1);
    checkFrame("trunc", fd0, ob, wb);

    // Abort during capture.
    $display("[TB] abort");
    rdy_mode = 0;
    fd0 = fd_count;
    pulseStart();
    cam_vsync = 1'b1; repeat (3) tick();
    cam_vsync = 1'b0; repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      cam_href = 1'b1; cam_de = 1'b1; cam_data = DW'($urandom);
      tick();
      cam_de = 1'b0;
    end
    cam_href = 1'b0;
    tick();
    abort = 1'b1;
    #1;
    checkOutput("abort_rd_gated", fifo_rd, 0);
    tick();
    abort = 1'b0;
    checkOutput("abort_idle", busy, 0);
    checkOutput("abort_valid_clear", out_valid, 0);
    rb = rd_count; wb = wr_count;
    repeat (10) tick();
    checkOutput("abort_no_done", fd_count - fd0, 0);
    checkOutput("abort_cnt_kept", byte_cnt, 3);
    checkOutput("abort_no_rd", rd_count - rb, 0);
    checkOutput("abort_no_wr", wr_count - wb, 0);

    // Start and abort together: abort wins.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checkOutput("start_abort_idle", busy, 0);

`ifdef CAM_FIFO_CTRL_CONTINUOUS_EN
    // Second frame without a second start.
    $display("[TB] continuous");
    rdy_mode = 1;
    resetModel();
    fd0 = fd_count;
    pulseStart();
    applyStimulus(4, 1'b0, -1, -1);
    for (int k = 0; k < 400 && fd_count == fd0; k++) tick();
    checkOutput("cont1_done_seen", (fd_count > fd0), 1);
    repeat (3) tick();
    resetModel();
    fd0 = fd_count; ob = out_log.size(); wb = wr_count;
    applyStimulus(5, 1'b0, -1, -1);
    checkFrame("cont2", fd0, ob, wb);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
